cic_interpolator: RTL
=====================

CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 8: input sample width, two's complement.
REQ-002 SHALL have parameter RATE, default 4: interpolation factor; power of 2, at least 2.
REQ-003 SHALL have parameter N, default 2: number of comb stages and number of integrator stages; range 1..6; differential delay fixed at 1.
REQ-004 SHALL have derived localparam WIDTH_OUT = WIDTH_IN + (N-1)*log2(RATE).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port in, input, WIDTH_IN bits: input sample.
REQ-008 SHALL have port in_valid, input, 1 bit: in holds a sample.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-010 SHALL have port out, output, WIDTH_OUT bits: interpolated sample, one per clk, registered.
REQ-011 SHALL have port out_valid, output, 1 bit: out carries filtered data.
REQ-012 SHALL have port underrun, output, 1 bit: one-cycle pulse; an input slot passed without a sample.

Function
REQ-013 SHALL keep phase counter ph, 0..RATE-1: +1 every clk, RATE-1 wraps to 0.
REQ-014 SHALL drive in_ready = (ph == 0) while rstn high, 0 while rstn low; in_ready SHALL NOT depend on in_valid.
REQ-015 SHALL accept in only on a clk edge with in_ready && in_valid; in_valid high outside slots SHALL have no effect; unconsumed data may be held by the source.
REQ-016 SHALL use sample x = 0 on a slot edge with in_valid low, and SHALL pulse underrun high for the following cycle.
REQ-017 SHALL sign-extend x to WIDTH_OUT; all internal arithmetic SHALL be WIDTH_OUT bits, two's complement, wrap-around (no saturation).
REQ-018 Comb section: SHALL compute c0 = x, ck = c(k-1) - d(k-1) for k = 1..N combinationally; delay registers dk <= ck SHALL update only on slot edges.
REQ-019 Upsampler register s: SHALL load cN on slot edges and 0 on all other edges (zero stuffing).
REQ-020 Integrators: SHALL update every edge, i1 <= i1 + s and ik <= ik + i(k-1); out = iN.
REQ-021 Latency: a sample accepted on edge t SHALL first affect out after edge t+N+1.
REQ-022 DC gain SHALL be RATE^(N-1): constant input v in every slot settles to out = v*RATE^(N-1).
REQ-023 out_valid SHALL rise after edge t+N+1 following the first slot edge after reset, and SHALL stay high until reset; underrun slots SHALL NOT drop it.
REQ-024 SHALL flag illegal parameters at elaboration: RATE not a power of 2, RATE < 2, or N outside 1..6.

Reset
REQ-025 rstn low SHALL immediately clear ph, all dk, s and all ik, and drive out = 0, out_valid = 0, underrun = 0 and in_ready = 0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard all filter history; no output from before reset SHALL appear after reset.
REQ-027 The first clk edge after rstn rises SHALL be a slot edge (ph = 0).

Verification (N=2, RATE=4, WIDTH_IN=8, WIDTH_OUT=10)
REQ-028 Impulse: in=1 in the first slot, 0 in later slots -> out = 1,2,3,4,3,2,1,0 on consecutive cycles starting 3 edges after acceptance, then 0; out_valid rises with the first 1.
REQ-029 DC: in=5 in every slot -> out ramps and settles to 20, holding 20 at every cycle; no underrun.
REQ-030 Negative full-scale: in=-128 in every slot -> out settles to -512 with no wrap; in=127 -> out settles to 508.
REQ-031 Underrun: in_valid low during one slot of a DC=5 stream -> underrun high exactly one cycle after that slot; output equals the DC response with that slot's sample replaced by 0; out_valid stays 1.
REQ-032 Handshake: in_valid held high with in=7 across a slot plus 3 non-slot cycles -> exactly one sample consumed per slot; in_ready high only when ph=0.
REQ-033 Reset mid-stream: rstn low for 2 cycles during the DC=20 steady state -> out=0, out_valid=0 and in_ready=0 asynchronously; after release, first edge is a slot and the impulse test of REQ-028 passes unchanged.

Source files
------------

// File: rtl/cic_interpolator.sv
// CIC interpolator: N comb stages at the input rate, zero-stuffing upsampler,
// N integrators at the output rate, with a registered output.
module cic_interpolator #(
    parameter int WIDTH_IN  = 8,
    parameter int RATE      = 4,
    parameter int N         = 2,
    localparam int WIDTH_OUT = WIDTH_IN + (N - 1) * $clog2(RATE)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [WIDTH_IN-1:0]  in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH_OUT-1:0] out,
    output logic                 out_valid,
    output logic                 underrun
);

    localparam int PH_W = (RATE > 1) ? $clog2(RATE) : 1;

    if (RATE < 2 || (RATE & (RATE - 1)) != 0) begin : g_bad_rate
        $error("cic_interpolator: RATE must be a power of 2 and at least 2");
    end
    if (N < 1 || N > 6) begin : g_bad_n
        $error("cic_interpolator: N must be in 1..6");
    end

    function automatic logic signed [WIDTH_OUT-1:0] sext(input logic signed [WIDTH_IN-1:0] v);
        return WIDTH_OUT'(v);
    endfunction

    logic [PH_W-1:0]             ph;
    logic                        slot;
    logic signed [WIDTH_OUT-1:0] x_p0;
    logic signed [WIDTH_OUT-1:0] comb_c_p0 [N];
    logic signed [WIDTH_OUT-1:0] comb_n_p0;
    logic signed [WIDTH_OUT-1:0] comb_d [N];
    logic signed [WIDTH_OUT-1:0] s_p1;
    logic signed [WIDTH_OUT-1:0] integ_p2 [N];
    logic signed [WIDTH_OUT-1:0] out_p3;
    logic [N+1:0]                vld_p;

    assign slot     = (ph == '0);
    assign in_ready = rstn & slot;
    assign x_p0     = (slot && in_valid) ? sext($signed(in)) : '0;

    always_comb begin
        logic signed [WIDTH_OUT-1:0] acc;
        acc = x_p0;
        for (int k = 0; k < N; k++) begin
            comb_c_p0[k] = acc;
            acc          = acc - comb_d[k];
        end
        comb_n_p0 = acc;
    end

    // Control: ph wraps on its own because RATE is a power of 2
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph       <= '0;
            underrun <= 1'b0;
            vld_p    <= '0;
        end else begin
            ph       <= ph + 1'b1;
            underrun <= slot & ~in_valid;
            vld_p    <= {vld_p[N:0], 1'b1};
        end
    end

    // Stage p0 -> p1: comb delays advance only on slot edges; zero stuffing otherwise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N; k++) comb_d[k] <= '0;
            s_p1 <= '0;
        end else begin
            if (slot) begin
                for (int k = 0; k < N; k++) comb_d[k] <= comb_c_p0[k];
            end
            s_p1 <= slot ? comb_n_p0 : '0;
        end
    end

    // Stage p1 -> p2 -> p3: integrator chain, then output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N; k++) integ_p2[k] <= '0;
            out_p3 <= '0;
        end else begin
            integ_p2[0] <= integ_p2[0] + s_p1;
            for (int k = 1; k < N; k++) integ_p2[k] <= integ_p2[k] + integ_p2[k-1];
            out_p3 <= integ_p2[N-1];
        end
    end

    assign out       = out_p3;
    assign out_valid = vld_p[N+1];

endmodule
